framebuffer_reader: RTL



---
 rtl/vga_fb_pkg.sv | 16 +
 rtl/read_latency_pipe.sv | 32 +++
 rtl/framebuffer_reader.sv | 106 ++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants for the VGA framebuffer read path: default geometry and
// the reader FSM state encoding.
package vga_fb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int WORD_W_DEF = 32;
    localparam int FB_DEPTH   = 1 << ADDR_W_DEF;

    typedef logic [1:0] fb_state_t;

    localparam fb_state_t ST_IDLE  = 2'd0;
    localparam fb_state_t ST_ISSUE = 2'd1;
    localparam fb_state_t ST_DRAIN = 2'd2;
    localparam fb_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/read_latency_pipe.sv
// Delay line that tracks which RAM read slots carry a real request, so the
// returning q can be qualified RD_LATENCY cycles after its address.
module read_latency_pipe #(
    parameter int RD_LATENCY = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic valid_in,
    output logic valid_out,
    output logic busy
);

    logic [RD_LATENCY-1:0] stages;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; blocking here would collapse
    // the delay line into a single register.
    always_ff @(posedge clock) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages[0] <= valid_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign valid_out = stages[RD_LATENCY-1];
    assign busy      = |stages;

endmodule

// File: rtl/framebuffer_reader.sv
// Reads WORD_W consecutive 1-bit pixels from the framebuffer RAM starting at a
// latched base address and packs them into one word with a done pulse.
module framebuffer_reader
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int WORD_W     = WORD_W_DEF,
    parameter int RD_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       endereco_base,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden,
    input  logic              q,
    output logic [WORD_W-1:0] dados_out,
    output logic              done,
    output logic              ready
);

    localparam int               CNT_W  = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WORD_W - 1);

    fb_state_t         state;
    logic [ADDR_W-1:0] base_reg;
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] shift_reg;
    logic              valid_out;
    logic              pipe_busy;
    logic              unused_base_bits;

    assign unused_base_bits = ^endereco_base[31:ADDR_W];

    read_latency_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_valid_pipe (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (rden),
        .valid_out (valid_out),
        .busy      (pipe_busy)
    );

    // The address for slot k+1 is registered while slot k is on the bus, so
    // slot 0 is loaded straight from the base on acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            base_reg  <= '0;
            count     <= '0;
            rdaddress <= '0;
            rden      <= 1'b0;
            dados_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_reg  <= endereco_base[ADDR_W-1:0];
                        count     <= '0;
                        rdaddress <= endereco_base[ADDR_W-1:0];
                        rden      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (count == LAST_K) begin
                        rden  <= 1'b0;
                        state <= ST_DRAIN;
                    end else begin
                        count     <= count + 1'b1;
                        rdaddress <= base_reg + ADDR_W'(count) + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Empty pipe means the last in-flight pixel was already captured.
                    if (!pipe_busy) begin
                        dados_out <= shift_reg;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the assembly register is reset even though a burst overwrites it
    // completely; it is a handful of flops, not a memory array, and a known
    // value keeps an aborted burst from leaking into simulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (valid_out) begin
            shift_reg <= {q, shift_reg[WORD_W-1:1]};
        end
    end

    assign done  = (state == ST_DONE);
    assign ready = (state == ST_IDLE);

endmodule
